// File: rtl/fpu_issue.sv
// ----------------------------------------------------------------------------
// fpu_issue
//   Issue stage in front of the FP pipeline (PRE -> EX -> NORMAL). It takes
//   instructions from decode over valid/ready and registers them into the FPU
//   instruction input. It holds back any instruction that would read an FP
//   register before an in-flight producer has written it, and issues NOP
//   bubbles in the meantime.
//
//   Ports
//     clk          clock, rising edge
//     rst          asynchronous, active-high reset
//     in_valid     decode presents an instruction on in_inst
//     in_ready     issue accepts in_inst this cycle
//     in_inst      candidate RISC-V instruction
//     flush        pipeline redirect; the issue register is discarded
//     inst_o       registered instruction to the FPU PRE stage
//     issue_valid  inst_o holds a real FP instruction (not a bubble)
//     hazard       combinational: the current candidate is blocked by RAW
//     stall_cnt    saturating count of hazard-stall cycles
// ----------------------------------------------------------------------------
module fpu_issue #(
  parameter bit          BYPASS_WB = 1'b0,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic [31:0] inst_o,
  output logic        issue_valid,
  output logic        hazard,
  output logic [15:0] stall_cnt
);

  localparam logic [6:0] OPC_OP_FP = 7'b1010011;
  localparam logic [6:0] OPC_FSW   = 7'b0100111;

  // Destination of an instruction still in flight in the FPU.
  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } track_t;

  track_t s0;  // instruction in PRE (the issue register)
  track_t s1;  // instruction in EX

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       is_op_fp, is_fsw, is_fp;
  logic       rs1_busy, rs2_busy;
  logic       accept;

  assign opcode   = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign rs1      = in_inst[19:15];
  assign rs2      = in_inst[24:20];
  assign is_op_fp = (opcode == OPC_OP_FP);
  assign is_fsw   = (opcode == OPC_FSW);
  assign is_fp    = is_op_fp | is_fsw;

  // A producer in EX has not written yet unless the register file forwards
  // same-cycle write data, in which case only the PRE-stage producer blocks.
  assign rs1_busy = (s0.wr && (s0.rd == rs1)) ||
                    (!BYPASS_WB && s1.wr && (s1.rd == rs1));
  assign rs2_busy = (s0.wr && (s0.rd == rs2)) ||
                    (!BYPASS_WB && s1.wr && (s1.rd == rs2));

  // FSW's rs1 is an integer base register, so only OP-FP checks rs1.
  assign hazard   = in_valid && ((is_op_fp && rs1_busy) || (is_fp && rs2_busy));

  // During a flush the candidate is consumed and dropped, never stalled.
  assign in_ready = flush || !hazard;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o      <= NOP_INST;
      issue_valid <= 1'b0;
      s0          <= '0;
      s1          <= '0;
      stall_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make s1 take the pre-edge s0 even
      // though s0 is reloaded in the same block; blocking would collapse
      // the two-stage tracking into one.
      s1 <= s0;

      if (flush) begin
        inst_o      <= NOP_INST;
        issue_valid <= 1'b0;
        s0          <= '0;
      end else if (accept) begin
        inst_o      <= is_fp ? in_inst : NOP_INST;
        issue_valid <= is_fp;
        s0          <= '{wr: is_op_fp, rd: rd};
      end else begin
        inst_o      <= NOP_INST;
        issue_valid <= 1'b0;
        s0          <= '0;
      end

      if (hazard && !flush && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// ----------------------------------------------------------------------------
// tb_fpu_issue
//   Self-checking bench for fpu_issue. dut0 has no write-back bypass, dut1
//   has it. Each cycle the expected issue-register contents are pushed to a
//   scoreboard queue when stimulus is driven and popped after the edge.
// ----------------------------------------------------------------------------
module tb_fpu_issue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;

  logic        v0, fl0, rdy0, ov0, hz0;
  logic [31:0] i0, o0;
  logic [15:0] sc0;

  logic        v1, fl1, rdy1, ov1, hz1;
  logic [31:0] i1, o1;
  logic [15:0] sc1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        vld;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  fpu_issue #(.BYPASS_WB(1'b0), .NOP_INST(NOP)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_inst(i0),
    .flush(fl0), .inst_o(o0), .issue_valid(ov0), .hazard(hz0), .stall_cnt(sc0)
  );

  fpu_issue #(.BYPASS_WB(1'b1), .NOP_INST(NOP)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_inst(i1),
    .flush(fl1), .inst_o(o1), .issue_valid(ov1), .hazard(hz1), .stall_cnt(sc1)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- encoders
  function automatic logic [31:0] fop(input logic [6:0] f7, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] fadd(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return fop(7'b0000000, rd, rs1, rs2);
  endfunction

  function automatic logic [31:0] fmul(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return fop(7'b0001000, rd, rs1, rs2);
  endfunction

  // fsw rs2, 0(rs1)
  function automatic logic [31:0] fsw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100111};
  endfunction

  // Integer add, opcode 0x33.
  function automatic logic [31:0] iadd(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic fp_opcode(input logic [31:0] inst);
    return (inst[6:0] == 7'b1010011) || (inst[6:0] == 7'b0100111);
  endfunction

  // ------------------------------------------------------------ cycle driver
  // Called at a falling edge. Drives one cycle of stimulus into the selected
  // DUT, checks the combinational hazard/ready against the caller's
  // expectation, then checks the issue register after the rising edge.
  task automatic cycle(input int sel, input logic v, input logic [31:0] inst,
                       input logic fl, input logic exp_hz, input string name);
    exp_t        e;
    logic        hz, rdy, ov;
    logic [31:0] o;
    if (sel == 0) begin v0 = v; i0 = inst; fl0 = fl; end
    else          begin v1 = v; i1 = inst; fl1 = fl; end
    #1;
    hz  = (sel == 0) ? hz0  : hz1;
    rdy = (sel == 0) ? rdy0 : rdy1;
    n_checks++;
    if (hz !== exp_hz)
      $display("FAIL %s hazard: got %b expected %b", name, hz, exp_hz);
    else n_pass++;
    n_checks++;
    if (rdy !== (fl || !exp_hz))
      $display("FAIL %s in_ready: got %b expected %b", name, rdy, fl || !exp_hz);
    else n_pass++;

    if (!fl && v && !exp_hz && fp_opcode(inst)) e = '{vld: 1'b1, inst: inst};
    else                                        e = '{vld: 1'b0, inst: NOP};
    exp_q.push_back(e);

    @(posedge clk);
    @(negedge clk);
    o  = (sel == 0) ? o0  : o1;
    ov = (sel == 0) ? ov0 : ov1;
    e  = exp_q.pop_front();
    n_checks++;
    if (o !== e.inst || ov !== e.vld)
      $display("FAIL %s issue: got %h/%b expected %h/%b", name, o, ov, e.inst, e.vld);
    else n_pass++;
  endtask

  task automatic idle(input int sel, input string name);
    cycle(sel, 1'b0, 32'h0, 1'b0, 1'b0, name);
  endtask

  task automatic do_reset();
    v0 = 1'b0; i0 = '0; fl0 = 1'b0;
    v1 = 1'b0; i1 = '0; fl1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_cnt(input logic [15:0] got, input logic [15:0] exp, input string name);
    n_checks++;
    if (got !== exp) $display("FAIL %s stall_cnt: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (o0 !== NOP || ov0 !== 1'b0 || sc0 !== 16'h0 || rdy0 !== 1'b1)
      $display("FAIL reset_state: got %h/%b/%h/%b expected %h/0/0000/1",
               o0, ov0, sc0, rdy0, NOP);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    cycle(0, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "mid_fadd");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "mid_stall1");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "mid_stall2");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b0, "mid_fmul");
    // fmul now sits in PRE; a dependent candidate is held by it.
    v0 = 1'b1; i0 = fadd(5'd9, 5'd7, 5'd7); fl0 = 1'b0;
    #1;
    n_checks++;
    if (hz0 !== 1'b1) $display("FAIL mid_pre_rst hazard: got %b expected 1", hz0);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o0 !== NOP || ov0 !== 1'b0 || sc0 !== 16'h0)
      $display("FAIL mid_rst outputs: got %h/%b/%h expected %h/0/0000", o0, ov0, sc0, NOP);
    else n_pass++;
    n_checks++;
    if (hz0 !== 1'b0 || rdy0 !== 1'b1)
      $display("FAIL mid_rst ready: got hz %b rdy %b expected 0 1", hz0, rdy0);
    else n_pass++;
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(0, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "b2b_first");
    cycle(0, 1'b1, fadd(5'd4, 5'd5, 5'd6), 1'b0, 1'b0, "b2b_second");
    idle(0, "b2b_idle");
    check_cnt(sc0, 16'd0, "b2b");
  endtask

  task automatic test_raw_no_bypass();
    do_reset();
    cycle(0, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "raw0_fadd");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "raw0_stall_pre");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "raw0_stall_ex");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b0, "raw0_fmul");
    idle(0, "raw0_idle");
    check_cnt(sc0, 16'd2, "raw0");
  endtask

  task automatic test_raw_bypass();
    do_reset();
    cycle(1, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "raw1_fadd");
    cycle(1, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "raw1_stall");
    cycle(1, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b0, "raw1_fmul");
    idle(1, "raw1_idle");
    check_cnt(sc1, 16'd1, "raw1");
  endtask

  task automatic test_fsw();
    do_reset();
    cycle(0, 1'b1, fadd(5'd9, 5'd2, 5'd3), 1'b0, 1'b0, "fsw_prod");
    cycle(0, 1'b1, fsw(5'd9, 5'd9), 1'b0, 1'b1, "fsw_stall1");
    cycle(0, 1'b1, fsw(5'd9, 5'd9), 1'b0, 1'b1, "fsw_stall2");
    cycle(0, 1'b1, fsw(5'd9, 5'd9), 1'b0, 1'b0, "fsw_issue");
    cycle(0, 1'b1, fadd(5'd9, 5'd2, 5'd3), 1'b0, 1'b0, "fsw_prod2");
    cycle(0, 1'b1, fsw(5'd2, 5'd9), 1'b0, 1'b0, "fsw_int_base");
    // f0 is an ordinary FP register.
    cycle(0, 1'b1, fadd(5'd0, 5'd4, 5'd5), 1'b0, 1'b0, "f0_prod");
    cycle(0, 1'b1, fadd(5'd3, 5'd0, 5'd0), 1'b0, 1'b1, "f0_stall");
    idle(0, "fsw_idle");
    check_cnt(sc0, 16'd3, "fsw");
  endtask

  task automatic test_flush();
    do_reset();
    cycle(0, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "fl_fadd");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b1, 1'b1, "fl_drop");
    idle(0, "fl_bubble");
    check_cnt(sc0, 16'd0, "fl_no_count");
    // The flushed fadd still completes: it is tracked in EX after the flush.
    do_reset();
    cycle(0, 1'b1, fadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "fl2_fadd");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b1, 1'b1, "fl2_drop");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b1, "fl2_ex_stall");
    cycle(0, 1'b1, fmul(5'd7, 5'd1, 5'd4), 1'b0, 1'b0, "fl2_fmul");
    check_cnt(sc0, 16'd1, "fl2");
  endtask

  task automatic test_non_fp();
    do_reset();
    cycle(0, 1'b1, iadd(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, "int_issue");
    cycle(0, 1'b1, fadd(5'd3, 5'd1, 5'd1), 1'b0, 1'b0, "int_no_wr");
    cycle(0, 1'b1, iadd(5'd4, 5'd3, 5'd3), 1'b0, 1'b0, "int_no_rd");
    idle(0, "int_idle");
    check_cnt(sc0, 16'd0, "int");
  endtask

  task automatic test_saturation();
    do_reset();
    // Preload the counter near its limit rather than spending ~100k cycles.
    force dut0.stall_cnt = 16'hFFFD;
    #1;
    release dut0.stall_cnt;
    cycle(0, 1'b1, fadd(5'd1, 5'd1, 5'd1), 1'b0, 1'b0, "sat_a");
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1'b1, fadd(5'd1, 5'd1, 5'd1), 1'b0, 1'b1, "sat_stall_a");
      cycle(0, 1'b1, fadd(5'd1, 5'd1, 5'd1), 1'b0, 1'b1, "sat_stall_b");
      cycle(0, 1'b1, fadd(5'd1, 5'd1, 5'd1), 1'b0, 1'b0, "sat_issue");
    end
    check_cnt(sc0, 16'hFFFF, "sat");
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; i0 = '0; fl0 = 1'b0;
    v1 = 1'b0; i1 = '0; fl1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_mid_stream();
    test_back_to_back();
    test_raw_no_bypass();
    test_raw_bypass();
    test_fsw();
    test_flush();
    test_non_fp();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
